// File: rtl/fp32_other_issue_arbiter_if.sv
// Request / shared-unit / response bundle for fp32_other_issue_arbiter.
// master = lanes plus the shared unit; slave = the arbiter.
interface fp32_other_issue_arbiter_if #(
    parameter int TAG_WIDTH = 6,
    parameter int CODE_W    = 5,
    parameter int RM_W      = 3,
    parameter int FFLAGS_W  = 5
);
    logic                           flush;
    logic [1:0]                     req_valid;
    logic [1:0]                     req_ready;
    logic [1:0][31:0]               req_lhs;
    logic [1:0][31:0]               req_rhs;
    logic [1:0][CODE_W-1:0]         req_code;
    logic [1:0][RM_W-1:0]           req_rm;
    logic [1:0][TAG_WIDTH-1:0]      req_tag;
    logic [31:0]                    fu_lhs;
    logic [31:0]                    fu_rhs;
    logic [CODE_W-1:0]              fu_code;
    logic [RM_W-1:0]                fu_rm;
    logic [31:0]                    fu_result;
    logic [FFLAGS_W-1:0]            fu_fflags;
    logic                           rsp_valid;
    logic                           rsp_lane;
    logic [TAG_WIDTH-1:0]           rsp_tag;
    logic [31:0]                    rsp_result;
    logic [FFLAGS_W-1:0]            rsp_fflags;
    logic [1:0]                     rsp_release;

    modport master (
        output flush, req_valid, req_lhs, req_rhs, req_code, req_rm, req_tag,
        input  req_ready,
        input  fu_lhs, fu_rhs, fu_code, fu_rm,
        output fu_result, fu_fflags,
        input  rsp_valid, rsp_lane, rsp_tag, rsp_result, rsp_fflags,
        output rsp_release
    );

    modport slave (
        input  flush, req_valid, req_lhs, req_rhs, req_code, req_rm, req_tag,
        output req_ready,
        output fu_lhs, fu_rhs, fu_code, fu_rm,
        input  fu_result, fu_fflags,
        output rsp_valid, rsp_lane, rsp_tag, rsp_result, rsp_fflags,
        input  rsp_release
    );
endinterface

// File: rtl/fp32_other_issue_arbiter.sv
// Two-lane round-robin issue arbiter in front of one shared FP32 "other" unit, with
// lane/tag tracking and per-lane credits. Optional counters: RSD_FP_OTHER_ARB_PERF_EN.
module fp32_other_issue_arbiter #(
    parameter int         PIPELINE_DEPTH = 5,
    parameter int         TAG_WIDTH      = 6,
    parameter int         CREDITS        = 4,
    parameter logic [4:0] DEFAULT_CODE   = 5'd0
) (
    input  logic                    clk,
    input  logic                    rst,
    fp32_other_issue_arbiter_if.slave bus
`ifdef RSD_FP_OTHER_ARB_PERF_EN
    ,
    output logic [31:0]             perf_issue_cnt,
    output logic [31:0]             perf_conflict_cnt
`endif
);
    localparam int         LAT      = PIPELINE_DEPTH - 1;
    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    logic [1:0][3:0]            credit_q, credit_d;
    logic                       rr_q, rr_d;
    logic [LAT-1:0]             trk_v_q, trk_v_d;
    logic [LAT-1:0]             trk_lane_q, trk_lane_d;
    logic [LAT-1:0][TAG_WIDTH-1:0] trk_tag_q, trk_tag_d;

    logic [1:0]                 elig_s;
    logic [1:0]                 grant_s;
    logic                       issue_s;
    logic                       lane_s;
    logic                       dec_s;

    // Eligibility, round-robin grant and operand steering to the shared unit.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            elig_s[i] = bus.req_valid[i] & (credit_q[i] < CRED_MAX) & ~bus.flush & ~rst;
        end
        if (elig_s == 2'b11) begin
            grant_s = rr_q ? 2'b10 : 2'b01;
        end else begin
            grant_s = elig_s;
        end
        issue_s       = |grant_s;
        lane_s        = grant_s[1];
        bus.req_ready = grant_s;
        if (issue_s) begin
            bus.fu_lhs  = bus.req_lhs[lane_s];
            bus.fu_rhs  = bus.req_rhs[lane_s];
            bus.fu_code = bus.req_code[lane_s];
            bus.fu_rm   = bus.req_rm[lane_s];
        end else begin
            bus.fu_lhs  = 32'd0;
            bus.fu_rhs  = 32'd0;
            bus.fu_code = DEFAULT_CODE;
            bus.fu_rm   = 3'd0;
        end
    end

    // Next state: pointer, credits and the tracker shift register.
    always_comb begin
        dec_s = 1'b0;
        if (issue_s) begin
            rr_d = ~lane_s;
        end else begin
            rr_d = rr_q;
        end
        for (int i = 0; i < 2; i++) begin
            // A release against an empty counter is dropped rather than wrapping.
            dec_s = bus.rsp_release[i] & (credit_q[i] != 4'd0);
            if (bus.flush) begin
                credit_d[i] = 4'd0;
            end else begin
                credit_d[i] = credit_q[i] + {3'd0, grant_s[i]} - {3'd0, dec_s};
            end
        end
        if (bus.flush) begin
            trk_v_d = {LAT{1'b0}};
        end else begin
            trk_v_d = {trk_v_q[LAT-2:0], issue_s};
        end
        trk_lane_d   = {trk_lane_q[LAT-2:0], lane_s};
        trk_tag_d[0] = bus.req_tag[lane_s];
        for (int k = 1; k < LAT; k++) begin
            trk_tag_d[k] = trk_tag_q[k-1];
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q   <= {2{4'd0}};
            rr_q       <= 1'b0;
            trk_v_q    <= {LAT{1'b0}};
            trk_lane_q <= {LAT{1'b0}};
            trk_tag_q  <= {(LAT*TAG_WIDTH){1'b0}};
        end else begin
            credit_q   <= credit_d;
            rr_q       <= rr_d;
            trk_v_q    <= trk_v_d;
            trk_lane_q <= trk_lane_d;
            trk_tag_q  <= trk_tag_d;
        end
    end

    // Responses come from the tracker tail; the unit data passes straight through.
    always_comb begin
        bus.rsp_valid  = trk_v_q[LAT-1] & ~bus.flush;
        bus.rsp_result = bus.fu_result;
        bus.rsp_fflags = bus.fu_fflags;
        if (bus.rsp_valid) begin
            bus.rsp_lane = trk_lane_q[LAT-1];
            bus.rsp_tag  = trk_tag_q[LAT-1];
        end else begin
            bus.rsp_lane = 1'b0;
            bus.rsp_tag  = {TAG_WIDTH{1'b0}};
        end
    end

`ifdef RSD_FP_OTHER_ARB_PERF_EN
    logic [31:0] perf_issue_q;
    logic [31:0] perf_conflict_q;
    logic        conflict_s;

    assign conflict_s        = (&bus.req_valid) & issue_s;
    assign perf_issue_cnt    = perf_issue_q;
    assign perf_conflict_cnt = perf_conflict_q;

    // Free-running event counters; flush leaves them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_q    <= 32'd0;
            perf_conflict_q <= 32'd0;
        end else begin
            perf_issue_q    <= perf_issue_q + {31'd0, issue_s};
            perf_conflict_q <= perf_conflict_q + {31'd0, conflict_s};
        end
    end
`endif
endmodule

// File: tb/tb_fp32_other_issue_arbiter.sv
// Randomized bench for fp32_other_issue_arbiter with a queue-based reference model
// and a stand-in pipelined unit.
module tb_fp32_other_issue_arbiter;
    localparam int         LAT     = 4;
    localparam int         CREDITS = 4;
    localparam logic [4:0] FC_FMIN = 5'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp32_other_issue_arbiter_if #(.TAG_WIDTH(6)) bus();

`ifdef RSD_FP_OTHER_ARB_PERF_EN
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_conflict_cnt;
`endif

    fp32_other_issue_arbiter #(.PIPELINE_DEPTH(5), .TAG_WIDTH(6), .CREDITS(CREDITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef RSD_FP_OTHER_ARB_PERF_EN
        ,
        .perf_issue_cnt    (perf_issue_cnt),
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    function automatic logic [31:0] unit_res(logic [31:0] a, logic [31:0] b, logic [4:0] c);
        if (c == FC_FMIN) return (a < b) ? a : b;
        return a ^ {b[15:0], b[31:16]} ^ {27'd0, c};
    endfunction

    function automatic logic [4:0] unit_ff(logic [31:0] a, logic [31:0] b, logic [4:0] c);
        return a[4:0] ^ b[9:5] ^ c;
    endfunction

    // Stand-in shared unit: fixed LAT-cycle pipeline fed from the arbiter outputs.
    logic [31:0] pr [LAT];
    logic [4:0]  pf [LAT];
    always @(posedge clk) begin
        pr[0] <= unit_res(bus.fu_lhs, bus.fu_rhs, bus.fu_code);
        pf[0] <= unit_ff(bus.fu_lhs, bus.fu_rhs, bus.fu_code);
        for (int k = 1; k < LAT; k++) begin
            pr[k] <= pr[k-1];
            pf[k] <= pf[k-1];
        end
    end
    assign bus.fu_result = pr[LAT-1];
    assign bus.fu_fflags = pf[LAT-1];

    typedef struct {
        int          due;
        bit          lane;
        logic [5:0]  tag;
        logic [31:0] res;
        logic [4:0]  ff;
    } rsp_t;

    rsp_t pend[$];
    int   cred[2];
    bit   last_lane;
    int   cyc;
    int   nchk = 0;
    int   nerr = 0;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        cred[0] = 0;
        cred[1] = 0;
        last_lane = 1'b1;
        pend.delete();
    endtask

    // One clock of checking: compare DUT against the model, then advance the model.
    task automatic step();
        int   g;
        bit   e0, e1, expv;
        logic [1:0] exp_ready;
        rsp_t it;
        #1;
        e0 = bus.req_valid[0] && (cred[0] < CREDITS) && !bus.flush;
        e1 = bus.req_valid[1] && (cred[1] < CREDITS) && !bus.flush;
        if (e0 && e1)  g = last_lane ? 0 : 1;
        else if (e0)   g = 0;
        else if (e1)   g = 1;
        else           g = -1;
        exp_ready = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
        chk("req_ready", {62'd0, bus.req_ready}, {62'd0, exp_ready});
        if (g >= 0) begin
            chk("fu_lhs",  {32'd0, bus.fu_lhs},  {32'd0, bus.req_lhs[g]});
            chk("fu_rhs",  {32'd0, bus.fu_rhs},  {32'd0, bus.req_rhs[g]});
            chk("fu_code", {59'd0, bus.fu_code}, {59'd0, bus.req_code[g]});
            chk("fu_rm",   {61'd0, bus.fu_rm},   {61'd0, bus.req_rm[g]});
        end else begin
            chk("fu_code_idle", {59'd0, bus.fu_code}, 64'd0);
        end
        expv = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            it = pend.pop_front();
            expv = !bus.flush;
        end
        chk("rsp_valid", {63'd0, bus.rsp_valid}, {63'd0, expv});
        if (expv) begin
            chk("rsp_lane",   {63'd0, bus.rsp_lane},   {63'd0, it.lane});
            chk("rsp_tag",    {58'd0, bus.rsp_tag},    {58'd0, it.tag});
            chk("rsp_result", {32'd0, bus.rsp_result}, {32'd0, it.res});
            chk("rsp_fflags", {59'd0, bus.rsp_fflags}, {59'd0, it.ff});
        end else begin
            chk("rsp_lane_idle", {63'd0, bus.rsp_lane}, 64'd0);
            chk("rsp_tag_idle",  {58'd0, bus.rsp_tag},  64'd0);
        end
        if (bus.flush) begin
            pend.delete();
            cred[0] = 0;
            cred[1] = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (bus.rsp_release[i] && cred[i] > 0) cred[i]--;
            end
            if (g >= 0) begin
                cred[g]++;
                last_lane = g[0];
                it.due  = cyc + LAT;
                it.lane = g[0];
                it.tag  = bus.req_tag[g];
                it.res  = unit_res(bus.req_lhs[g], bus.req_rhs[g], bus.req_code[g]);
                it.ff   = unit_ff(bus.req_lhs[g], bus.req_rhs[g], bus.req_code[g]);
                pend.push_back(it);
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.req_valid   = 2'b00;
        bus.rsp_release = 2'b00;
        bus.flush       = 1'b0;
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < 2; i++) begin
            bus.req_lhs[i]  = $urandom;
            bus.req_rhs[i]  = $urandom;
            bus.req_code[i] = 5'($urandom_range(0, 31));
            bus.req_rm[i]   = 3'($urandom_range(0, 7));
            bus.req_tag[i]  = 6'($urandom_range(0, 63));
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        idle();
        randomize_ops();
        bus.req_valid = 2'b11;
        cyc = 0;
        model_reset();
        #2;
        chk("reset_ready", {62'd0, bus.req_ready}, 64'd0);
        chk("reset_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Contention right after reset: alternate starting with lane 0.
        bus.req_tag[0] = 6'd10;
        bus.req_tag[1] = 6'd11;
        bus.req_valid  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 chk("contend_grant", {62'd0, bus.req_ready}, (k % 2 == 0) ? 64'd1 : 64'd2);
            step();
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("contend_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
            chk("contend_rsp_lane",  {63'd0, bus.rsp_lane},  64'(k % 2));
            chk("contend_rsp_tag",   {58'd0, bus.rsp_tag},   64'(10 + k % 2));
            step();
        end
        bus.rsp_release = 2'b11;
        repeat (2) step();
        idle();

        // Single FMIN on lane 0, answer exactly LAT cycles later.
        bus.req_lhs[0]  = 32'h3F80_0000;
        bus.req_rhs[0]  = 32'h4000_0000;
        bus.req_code[0] = FC_FMIN;
        bus.req_tag[0]  = 6'd5;
        bus.req_valid   = 2'b01;
        step();
        idle();
        repeat (3) step();
        #1;
        chk("single_rsp_valid",  {63'd0, bus.rsp_valid},  64'd1);
        chk("single_rsp_lane",   {63'd0, bus.rsp_lane},   64'd0);
        chk("single_rsp_tag",    {58'd0, bus.rsp_tag},    64'd5);
        chk("single_rsp_result", {32'd0, bus.rsp_result}, 64'h3F80_0000);
        step();
        bus.rsp_release = 2'b01;
        step();
        idle();

        // Credit exhaustion on lane 1, then one release reopens it.
        bus.req_valid = 2'b10;
        for (int k = 0; k < 4; k++) begin
            #1 chk("credit_accept", {62'd0, bus.req_ready}, 64'd2);
            step();
        end
        #1 chk("credit_block", {62'd0, bus.req_ready}, 64'd0);
        step();
        bus.rsp_release = 2'b10;
        #1 chk("credit_release_cycle", {62'd0, bus.req_ready}, 64'd0);
        step();
        bus.rsp_release = 2'b00;
        #1 chk("credit_reopen", {62'd0, bus.req_ready}, 64'd2);
        step();
        idle();
        bus.rsp_release = 2'b10;
        repeat (4) step();
        idle();

        // Flush with three ops in flight.
        bus.req_valid = 2'b01;
        repeat (3) step();
        idle();
        bus.flush     = 1'b1;
        bus.req_valid = 2'b11;
        #1 chk("flush_ready", {62'd0, bus.req_ready}, 64'd0);
        step();
        idle();
        for (int k = 0; k < 4; k++) begin
            #1 chk("flush_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            bus.req_valid = (i == 0) ? 2'b01 : 2'b10;
            for (int k = 0; k < 4; k++) begin
                #1 chk("flush_credits_clear", {62'd0, bus.req_ready}, (i == 0) ? 64'd1 : 64'd2);
                step();
            end
        end
        idle();
        bus.rsp_release = 2'b11;
        repeat (6) step();
        idle();

        // Asynchronous reset between edges.
        randomize_ops();
        bus.req_valid = 2'b11;
        repeat (3) step();
        #3 rst = 1'b1;
        #1;
        chk("async_rst_ready", {62'd0, bus.req_ready}, 64'd0);
        chk("async_rst_rsp",   {63'd0, bus.rsp_valid}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1 chk("post_rst_grant", {62'd0, bus.req_ready}, 64'd1);
        step();
        idle();
        bus.rsp_release = 2'b11;
        repeat (LAT + 2) step();
        idle();

`ifdef RSD_FP_OTHER_ARB_PERF_EN
        apply_reset();
        bus.req_valid   = 2'b11;
        bus.rsp_release = 2'b11;
        repeat (10) step();
        idle();
        #1;
        chk("perf_issue",    {32'd0, perf_issue_cnt},    64'd10);
        chk("perf_conflict", {32'd0, perf_conflict_cnt}, 64'd10);
        bus.rsp_release = 2'b11;
        repeat (LAT + 2) step();
        idle();
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            randomize_ops();
            bus.req_valid   = 2'($urandom_range(0, 3));
            bus.rsp_release = 2'($urandom_range(0, 3));
            bus.flush       = ($urandom_range(0, 31) == 0);
            step();
        end
        idle();
        repeat (LAT + 4) step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
